// File: rtl/cpu7_excp_ctl.sv
// cpu7_excp_ctl: exception / ERTN sequencer for the cpu7 core.
//
// Collects exception requests from the execute stage and prioritizes them
// (INT > INE > SYS > BRK > ALE > ERTN). It issues one-cycle commit pulses to
// the CSR file, then holds a fetch redirect until the fetch unit acknowledges.
// After that it keeps flush asserted for DRAIN_CYCLES more cycles while the
// pipeline drains. All outputs are registered.
//
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   ecl_*_e              execute-stage instruction info and exception requests
//   int_pending          external/timer interrupt pending
//   csr_crmd_ie          CRMD.IE (interrupts enabled)
//   csr_eentry, csr_era  exception entry / return address from the CSR file
//   ifu_redirect_ack     fetch unit accepted the redirect
//   excp_commit/ecode/era, excp_badv_we/badv   exception-entry commit to CSRs
//   ertn_commit          ERTN commit pulse (CRMD restored from PRMD)
//   flush, redirect_vld, redirect_pc, busy     pipeline control
module cpu7_excp_ctl #(
    parameter int unsigned GRLEN        = 32,
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             ecl_valid_e,
    input  logic [GRLEN-1:0] ecl_pc_e,
    input  logic             ecl_excp_ine_e,
    input  logic             ecl_excp_sys_e,
    input  logic             ecl_excp_brk_e,
    input  logic             ecl_excp_ale_e,
    input  logic [GRLEN-1:0] ecl_ale_vaddr_e,
    input  logic             ecl_ertn_e,
    input  logic             int_pending,
    input  logic             csr_crmd_ie,
    input  logic [GRLEN-1:0] csr_eentry,
    input  logic [GRLEN-1:0] csr_era,
    input  logic             ifu_redirect_ack,
    output logic             excp_commit,
    output logic [5:0]       excp_ecode,
    output logic [GRLEN-1:0] excp_era,
    output logic             excp_badv_we,
    output logic [GRLEN-1:0] excp_badv,
    output logic             ertn_commit,
    output logic             flush,
    output logic             redirect_vld,
    output logic [GRLEN-1:0] redirect_pc,
    output logic             busy
);

    localparam logic [5:0] ECODE_INT = 6'h00;
    localparam logic [5:0] ECODE_ALE = 6'h09;
    localparam logic [5:0] ECODE_SYS = 6'h0B;
    localparam logic [5:0] ECODE_BRK = 6'h0C;
    localparam logic [5:0] ECODE_INE = 6'h0D;

    localparam logic [3:0] DRAIN_LD = 4'(DRAIN_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REDIR,
        S_DRAIN
    } state_t;

    state_t           state_q;
    logic [3:0]       cnt_q;
    logic             commit_q;
    logic [5:0]       ecode_q;
    logic [GRLEN-1:0] era_q;
    logic             badv_we_q;
    logic [GRLEN-1:0] badv_q;
    logic             ertn_q;
    logic             flush_q;
    logic             rvld_q;
    logic [GRLEN-1:0] rpc_q;
    logic             busy_q;

    // Event decode, only meaningful while idle.
    logic       int_take;
    logic       exc_d;
    logic       ertn_d;
    logic       ale_sel_d;
    logic [5:0] ecode_d;

    always_comb begin
        int_take  = int_pending & csr_crmd_ie;
        exc_d     = ecl_valid_e & (int_take | ecl_excp_ine_e | ecl_excp_sys_e |
                                   ecl_excp_brk_e | ecl_excp_ale_e);
        ertn_d    = ecl_valid_e & ecl_ertn_e & ~exc_d;
        // ALE is the only source that writes BADV, and only when nothing above it fires.
        ale_sel_d = ecl_valid_e & ecl_excp_ale_e &
                    ~(int_take | ecl_excp_ine_e | ecl_excp_sys_e | ecl_excp_brk_e);
        ecode_d   = ECODE_ALE;
        if (int_take)            ecode_d = ECODE_INT;
        else if (ecl_excp_ine_e) ecode_d = ECODE_INE;
        else if (ecl_excp_sys_e) ecode_d = ECODE_SYS;
        else if (ecl_excp_brk_e) ecode_d = ECODE_BRK;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            commit_q  <= 1'b0;
            ecode_q   <= '0;
            era_q     <= '0;
            badv_we_q <= 1'b0;
            badv_q    <= '0;
            ertn_q    <= 1'b0;
            flush_q   <= 1'b0;
            rvld_q    <= 1'b0;
            rpc_q     <= '0;
            busy_q    <= 1'b0;
        end else begin
            commit_q  <= 1'b0;
            ertn_q    <= 1'b0;
            badv_we_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (exc_d || ertn_d) begin
                        state_q <= S_REDIR;
                        rvld_q  <= 1'b1;
                        flush_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                    if (exc_d) begin
                        commit_q <= 1'b1;
                        ecode_q  <= ecode_d;
                        era_q    <= ecl_pc_e;
                        rpc_q    <= csr_eentry;
                        if (ale_sel_d) begin
                            badv_we_q <= 1'b1;
                            badv_q    <= ecl_ale_vaddr_e;
                        end
                    end else if (ertn_d) begin
                        ertn_q <= 1'b1;
                        rpc_q  <= csr_era;
                    end
                end
                S_REDIR: begin
                    if (ifu_redirect_ack) begin
                        rvld_q <= 1'b0;
                        cnt_q  <= DRAIN_LD;
                        if (DRAIN_CYCLES == 0) begin
                            state_q <= S_IDLE;
                            flush_q <= 1'b0;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= S_IDLE;
                        flush_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    flush_q <= 1'b0;
                    rvld_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign excp_commit  = commit_q;
    assign excp_ecode   = ecode_q;
    assign excp_era     = era_q;
    assign excp_badv_we = badv_we_q;
    assign excp_badv    = badv_q;
    assign ertn_commit  = ertn_q;
    assign flush        = flush_q;
    assign redirect_vld = rvld_q;
    assign redirect_pc  = rpc_q;
    assign busy         = busy_q;

endmodule
